// File: rtl/mw_add_pkg.sv
// +--------------------------------------------------------------------+
// | mw_add_pkg: shared types and constants for the multi-word adder     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package mw_add_pkg;

  localparam int W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mw_add_seq_if.sv
// +--------------------------------------------------------------------+
// | mw_add_seq_if: operand/result handshake bundle (sub: MW_ADD_SUB_EN)|
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

interface mw_add_seq_if
  import mw_add_pkg::*;
#(
  parameter int WORDS = 4
);

  logic                 in_valid;
  logic                 in_ready;
  logic [WORDS*W-1:0]   A;
  logic [WORDS*W-1:0]   B;
  logic                 Cin;
`ifdef MW_ADD_SUB_EN
  logic                 sub;
`endif
  logic                 out_valid;
  logic                 out_ready;
  logic [WORDS*W-1:0]   Sum;
  logic                 Cout;
  logic                 Z;
  logic                 V;

  modport slave (
`ifdef MW_ADD_SUB_EN
    input  sub,
`endif
    input  in_valid, A, B, Cin, out_ready,
    output in_ready, out_valid, Sum, Cout, Z, V
  );

  modport master (
`ifdef MW_ADD_SUB_EN
    output sub,
`endif
    output in_valid, A, B, Cin, out_ready,
    input  in_ready, out_valid, Sum, Cout, Z, V
  );

endinterface

`default_nettype wire

// File: rtl/mw_add_csa.sv
// +--------------------------------------------------------------------+
// | mw_add_csa: 32-bit combinational carry-select adder, 8-bit blocks   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module mw_add_csa
  import mw_add_pkg::*;
(
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Cin,
  output logic [W-1:0] Sum,
  output logic         Cout,
  output logic         Z
);

  localparam int BLK = 8;
  localparam int NBLK = W / BLK;

  logic [NBLK:0] c;

  assign c[0] = Cin;

  for (genvar g = 0; g < NBLK; g++) begin : g_blk
    logic [BLK:0] s0;
    logic [BLK:0] s1;
    // Both carry-in outcomes are precomputed; the incoming carry only selects.
    assign s0 = {1'b0, A[g*BLK +: BLK]} + {1'b0, B[g*BLK +: BLK]};
    assign s1 = s0 + (BLK+1)'(1);
    assign Sum[g*BLK +: BLK] = c[g] ? s1[BLK-1:0] : s0[BLK-1:0];
    assign c[g+1]            = c[g] ? s1[BLK]     : s0[BLK];
  end

  assign Cout = c[NBLK];
  assign Z    = ~|Sum;

endmodule

`default_nettype wire

// File: rtl/mw_add_top.sv
// +--------------------------------------------------------------------+
// | mw_add_top: joins the sequencer to the carry-select adder           |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module mw_add_top
  import mw_add_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic         clk,
  input  logic         rst,
  mw_add_seq_if.slave  bus
);

  logic [W-1:0] add_A;
  logic [W-1:0] add_B;
  logic [W-1:0] add_Sum;
  logic         add_Cin;
  logic         add_Cout;
  logic         add_Z;

  mw_add_seq #(.WORDS(WORDS)) u_seq (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .add_A    (add_A),
    .add_B    (add_B),
    .add_Cin  (add_Cin),
    .add_Sum  (add_Sum),
    .add_Cout (add_Cout),
    .add_Z    (add_Z)
  );

  mw_add_csa u_csa (
    .A    (add_A),
    .B    (add_B),
    .Cin  (add_Cin),
    .Sum  (add_Sum),
    .Cout (add_Cout),
    .Z    (add_Z)
  );

endmodule

`default_nettype wire

// File: rtl/mw_add_seq.sv
// +--------------------------------------------------------------------+
// | mw_add_seq: feeds WORDS x 32-bit operands through the CSA, LSW first|
// | Rev 1.0 -- optional subtract via macro MW_ADD_SUB_EN                |
// +--------------------------------------------------------------------+
`default_nettype none

module mw_add_seq
  import mw_add_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic           clk,
  input  logic           rst,
  mw_add_seq_if.slave    bus,
  output logic [W-1:0]   add_A,
  output logic [W-1:0]   add_B,
  output logic           add_Cin,
  input  logic [W-1:0]   add_Sum,
  input  logic           add_Cout,
  input  logic           add_Z
);

  localparam int NB = WORDS * W;
  localparam int IW = clog2(WORDS);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  state_e          state_q;
  logic [NB-1:0]   a_q;
  logic [NB-1:0]   b_q;
  logic [NB-1:0]   sum_q;
  logic [IW-1:0]   idx_q;
  logic            carry_q;
  logic            zacc_q;
  logic            cout_q;
  logic            z_q;
  logic            v_q;
  logic [NB-1:0]   b_d;
  logic            carry_d;

`ifdef MW_ADD_SUB_EN
  // Subtraction is A + ~B + 1; the stored B is already the effective operand.
  assign b_d     = bus.sub ? ~bus.B : bus.B;
  assign carry_d = bus.sub ? 1'b1   : bus.Cin;
`else
  assign b_d     = bus.B;
  assign carry_d = bus.Cin;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      zacc_q  <= 1'b0;
      cout_q  <= 1'b0;
      z_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.A;
            b_q     <= b_d;
            carry_q <= carry_d;
            zacc_q  <= 1'b1;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q[idx_q*W +: W] <= add_Sum;
          carry_q             <= add_Cout;
          zacc_q              <= zacc_q & add_Z;
          idx_q               <= idx_q + 1'b1;
          if (idx_q == LAST) begin
            cout_q  <= add_Cout;
            z_q     <= zacc_q & add_Z;
            v_q     <= (a_q[NB-1] == b_q[NB-1]) & (add_Sum[W-1] != a_q[NB-1]);
            state_q <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    add_A   = '0;
    add_B   = '0;
    add_Cin = 1'b0;
    if (state_q == RUN) begin
      add_A   = a_q[idx_q*W +: W];
      add_B   = b_q[idx_q*W +: W];
      add_Cin = carry_q;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.Sum       = sum_q;
  assign bus.Cout      = cout_q;
  assign bus.Z         = z_q;
  assign bus.V         = v_q;

endmodule

`default_nettype wire

// File: tb/tb_mw_add_seq.sv
// +--------------------------------------------------------------------+
// | tb_mw_add_seq: table, corner-case and random checks of mw_add_seq   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_mw_add_seq;
  import mw_add_pkg::*;

  localparam int WORDS = 4;
  localparam int NB    = WORDS * W;

  typedef struct {
    logic [NB-1:0] a;
    logic [NB-1:0] b;
    logic          cin;
    logic [NB-1:0] sum;
    logic          cout;
    logic          z;
    logic          v;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [W-1:0] add_A, add_B, add_Sum;
  logic add_Cin, add_Cout, add_Z;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mw_add_seq_if #(.WORDS(WORDS)) bus ();

  mw_add_seq #(.WORDS(WORDS)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .add_A    (add_A),
    .add_B    (add_B),
    .add_Cin  (add_Cin),
    .add_Sum  (add_Sum),
    .add_Cout (add_Cout),
    .add_Z    (add_Z)
  );

  mw_add_csa u_csa (
    .A    (add_A),
    .B    (add_B),
    .Cin  (add_Cin),
    .Sum  (add_Sum),
    .Cout (add_Cout),
    .Z    (add_Z)
  );

  task automatic chk(input string nm, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Wide reference: {V, Z, Cout, Sum} from plain 129-bit arithmetic.
  function automatic logic [NB+2:0] ref_model(input logic [NB-1:0] a, input logic [NB-1:0] b,
                                              input logic cin, input logic sb);
    logic [NB-1:0] be;
    logic [NB:0]   wide;
    logic          v;
    be   = sb ? ~b : b;
    wide = {1'b0, a} + {1'b0, be} + (NB+1)'(sb ? 1'b1 : cin);
    v    = (a[NB-1] == be[NB-1]) && (wide[NB-1] != a[NB-1]);
    return {v, (wide[NB-1:0] == '0), wide[NB], wide[NB-1:0]};
  endfunction

  task automatic do_op(input string nm, input logic [NB-1:0] a, input logic [NB-1:0] b,
                       input logic cin, input logic [NB-1:0] esum, input logic ecout,
                       input logic ez, input logic ev, input int hold);
    int lat;
    int waitc;
    waitc = 0;
    while (!bus.in_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    chk({nm, ":in_ready_idle"}, NB'(bus.in_ready), NB'(1));
    bus.A        = a;
    bus.B        = b;
    bus.Cin      = cin;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk({nm, ":latency"}, NB'(lat), NB'(WORDS));
    chk({nm, ":sum"}, bus.Sum, esum);
    chk({nm, ":flags"}, NB'({bus.Cout, bus.Z, bus.V, bus.in_ready}), NB'({ecout, ez, ev, 1'b0}));
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk({nm, ":hold_sum"}, bus.Sum, esum);
      chk({nm, ":hold_flags"}, NB'({bus.out_valid, bus.in_ready, bus.Cout, bus.Z, bus.V}),
          NB'({1'b1, 1'b0, ecout, ez, ev}));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({nm, ":release"}, NB'({bus.out_valid, bus.in_ready}), NB'(2'b01));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t tbl[8];
    logic [NB-1:0] ones;
    logic [NB+2:0] r;
    logic [NB-1:0] ra, rb;
    logic rc;

    ones = '1;
    tbl[0] = '{'0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{ones, '0, 1'b1, '0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{128'hFFFF_FFFF, 128'd1, 1'b0, 128'h1_0000_0000, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0,
               128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{128'd5, 128'd7, 1'b0, 128'd12, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{128'h8000_0000_0000_0000_0000_0000_0000_0000,
               128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0, '0, 1'b1, 1'b1, 1'b1};
    tbl[6] = '{ones, 128'd1, 1'b0, '0, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{128'd1, 128'd2, 1'b1, 128'd4, 1'b0, 1'b0, 1'b0};

    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.Cin       = 1'b0;
`ifdef MW_ADD_SUB_EN
    bus.sub       = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    chk("reset:handshake", NB'({bus.in_ready, bus.out_valid}), NB'(2'b10));
    chk("reset:sum", bus.Sum, '0);
    chk("reset:flags", NB'({bus.Cout, bus.Z, bus.V}), NB'(0));
    chk("reset:add_bus", NB'({add_A, add_B, add_Cin}), NB'(0));

    for (int i = 0; i < 8; i++) begin
      do_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin,
            tbl[i].sum, tbl[i].cout, tbl[i].z, tbl[i].v, 0);
    end

    // Consumer stalls for 10 cycles with stray in_valid pulses.
    do_op("stall", tbl[3].a, tbl[3].b, 1'b0, tbl[3].sum, 1'b0, 1'b0, 1'b1, 10);

    // Reset in the middle of a run, with the word mux observed on the way.
    bus.A        = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    bus.B        = {32'h0, 32'h0, 32'h0, 32'h0000_0001};
    bus.Cin      = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("midrst:word0", NB'({add_A, add_B, add_Cin}), NB'({32'h1111_1111, 32'h1, 1'b0}));
    @(posedge clk);
    @(negedge clk);
    chk("midrst:word1", NB'({add_A, add_B, add_Cin}), NB'({32'h2222_2222, 32'h0, 1'b0}));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst:state", NB'({bus.in_ready, bus.out_valid, bus.Cout, bus.Z, bus.V}), NB'(5'b10000));
    chk("midrst:sum", bus.Sum, '0);
    do_op("after_rst", 128'd5, 128'd7, 1'b0, 128'd12, 1'b0, 1'b0, 1'b0, 0);

`ifdef MW_ADD_SUB_EN
    bus.sub = 1'b1;
    do_op("sub", 128'd5, 128'd7, 1'b1,
          128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 0);
    r = ref_model(128'd9, 128'd9, 1'b0, 1'b1);
    do_op("sub_eq", 128'd9, 128'd9, 1'b0, r[NB-1:0], r[NB], r[NB+1], r[NB+2], 0);
    bus.sub = 1'b0;
`endif

    // Random words biased towards 0 and all-ones to exercise carry chains.
    for (int n = 0; n < 24; n++) begin
      for (int w = 0; w < WORDS; w++) begin
        case ($urandom_range(0, 2))
          0:       ra[w*W +: W] = '0;
          1:       ra[w*W +: W] = '1;
          default: ra[w*W +: W] = $urandom;
        endcase
        case ($urandom_range(0, 2))
          0:       rb[w*W +: W] = '0;
          1:       rb[w*W +: W] = '1;
          default: rb[w*W +: W] = $urandom;
        endcase
      end
      rc = 1'($urandom_range(0, 1));
      r  = ref_model(ra, rb, rc, 1'b0);
      do_op($sformatf("rnd%0d", n), ra, rb, rc, r[NB-1:0], r[NB], r[NB+1], r[NB+2],
            int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
